demux1to2_stream: RTL and testbench
===================================

Name: demux1to2_stream

Overview:
- 1-to-2 stream demultiplexer: routes each input beat to output 0 or output 1, as selected by in_sel.
- It is the distribution-side counterpart of the team's 2-to-1 mux blocks.
- Each output has a 2-entry buffer with valid/ready handshakes, so backpressure on one output never corrupts or stalls the other output's already-buffered data.
- It sits between a single producer and two independent consumers.

Parameters:
- DW, 8, data width in bits.
- CW, 8, width of the optional per-output beat counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DW  input beat payload.
- in_sel  input  1  destination select: 0 = output 0, 1 = output 1; qualified by in_valid.
- in_valid  input  1  input beat present.
- in_ready  output  1  selected output buffer can accept a beat.
- out0_data  output  DW  head entry of output 0 buffer.
- out0_valid  output  1  output 0 buffer non-empty.
- out0_ready  input  1  consumer 0 accepts.
- out1_data  output  DW  head entry of output 1 buffer.
- out1_valid  output  1  output 1 buffer non-empty.
- out1_ready  input  1  consumer 1 accepts.
- cnt0  output  CW  beats delivered on output 0 (only with DEMUX_CNT_EN).
- cnt1  output  CW  beats delivered on output 1 (only with DEMUX_CNT_EN).

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values:
  - out0_valid = out1_valid = 0.
  - out0_data = out1_data = 0.
  - Both buffer FSMs in EMPTY.
  - cnt0 = cnt1 = 0.
- Reset mid-operation discards all buffered beats immediately, without waiting for a clock edge.
- Handshake events:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output k transfer: outk_valid & outk_ready at a rising edge.
- in_ready = in_sel ? !full1 : !full0. full0/full1 are registered; the only combinational path is the in_sel-to-in_ready mux.
  - in_ready is a don't-care when in_valid = 0.
  - in_ready must not depend on out0_ready or out1_ready.
- Latency:
  - A beat accepted at edge N appears on outk_data with outk_valid = 1 after edge N, so it is consumable at edge N+1.
  - Throughput: 1 beat/cycle sustained per output while its consumer holds ready = 1.
- Per-output buffer FSM (identical for both outputs):
  - States: EMPTY (0 entries), ONE (1 entry), TWO (2 entries, full).
  - EMPTY -> ONE on write.
  - ONE -> TWO on write without read.
  - ONE -> EMPTY on read without write.
  - ONE -> ONE on simultaneous write and read; head becomes the new beat.
  - TWO -> ONE on read. A write is impossible in TWO because in_ready = 0 for that output.
- Ordering: FIFO order is preserved within each output. No ordering relation is guaranteed between the two outputs.
- Stability: while outk_valid = 1 and outk_ready = 0, outk_data and outk_valid hold stable.
- A write targets only the buffer selected by in_sel. The non-selected buffer continues draining independently in the same cycle.
- Full boundary:
  - If the selected output is in TWO, the beat stalls: in_ready = 0, and the producer holds in_data and in_sel.
  - If the producer changes in_sel while stalled, in_ready re-evaluates combinationally against the new target.
- Empty boundary: reading when empty cannot occur, because outk_valid = 0 in that case.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - cnt0 and cnt1 ports exist.
  - cntk increments by 1 on each output-k transfer.
  - Wraps 2^CW-1 -> 0.
  - Cleared only by rst_n.
- Undefined:
  - Ports and counter logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared include/package demux_defs:
  - Buffer FSM state localparams ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2.
  - Select encodings SEL_OUT0 = 1'b0, SEL_OUT1 = 1'b1.
- Sub-module stream_fifo2 (parameter DW): 2-entry buffer with wr_valid/wr_ready and rd_valid/rd_ready, implementing the FSM above.
  - Instantiated twice.
  - The top level holds only the select steering, the in_ready mux and the optional counters.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with both buffers in TWO -> out0_valid = out1_valid = 0, in_ready = 1 for either in_sel, cnt0 = cnt1 = 0.
- Alternating route: send 8'hA0..8'hA7 with in_sel = 0,1,0,1..., both consumers ready = 1 -> out0 receives A0, A2, A4, A6 and out1 receives A1, A3, A5, A7, each one cycle after acceptance; no stalls.
- Isolation: out1_ready = 0; send 3 beats to out1 and then 4 beats to out0.
  - in_ready = 0 on the third out1 beat.
  - Out0 beats flow at 1/cycle once the producer switches in_sel to 0.
  - Out1 holds its first beat stable until out1_ready = 1.
- Simultaneous write/read: out0 in ONE holding 8'h11; write 8'h22 to out0 while out0_ready = 1 -> out0 delivers 11 then 22; FSM stays ONE.
- Counter wrap (DEMUX_CNT_EN, CW = 4): deliver 17 beats on output 0 -> cnt0 = 1, cnt1 = 0.
- Stall retarget: out0 full, in_valid = 1, in_sel = 0 gives in_ready = 0; switch in_sel to 1 with out1 empty -> in_ready = 1 in the same cycle; the beat lands in out1 only.

Source files
------------

// File: rtl/demux_defs_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer and its buffers.
// Buffer state encoding (EMPTY/ONE/TWO) and destination-select encodings.
package demux_defs;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

endpackage : demux_defs

// File: rtl/demux1to2_stream_fifo2.sv
// stream_fifo2: 2-entry valid/ready buffer. The head entry drives rd_data
// directly from a flop; a second entry holds the tail when the buffer is full.
// wr_ready depends only on registered state (no ready-to-ready path).
module stream_fifo2
    import demux_defs::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready
);

    buf_state_e    state_q, state_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          wr_fire;
    logic          rd_fire;

    assign wr_ready = (state_q != ST_TWO);
    assign rd_valid = (state_q != ST_EMPTY);
    assign rd_data  = head_q;
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = rd_valid & rd_ready;

    // State register and storage; reset discards all buffered entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Next-state and storage update for the EMPTY/ONE/TWO buffer FSM.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (wr_fire) begin
                    head_d  = wr_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (wr_fire && rd_fire) begin
                    head_d = wr_data;
                end else if (wr_fire) begin
                    tail_d  = wr_data;
                    state_d = ST_TWO;
                end else if (rd_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (rd_fire) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

endmodule : stream_fifo2

// File: rtl/demux1to2_stream.sv
// demux1to2_stream: routes each input beat to one of two buffered outputs
// selected by in_sel. Each output owns a stream_fifo2, so backpressure on one
// output never disturbs the other. Optional per-output delivered-beat
// counters (cnt0/cnt1) are present only when DEMUX_CNT_EN is defined.
module demux1to2_stream
    import demux_defs::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out0_data,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [DW-1:0] out1_data,
    output logic          out1_valid,
`ifdef DEMUX_CNT_EN
    input  logic          out1_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
`else
    input  logic          out1_ready
`endif
);

    logic wr_valid0, wr_valid1;
    logic wr_ready0, wr_ready1;

    // Steering: only the selected buffer sees the write request.
    always_comb begin
        wr_valid0 = in_valid & (in_sel == SEL_OUT0);
        wr_valid1 = in_valid & (in_sel == SEL_OUT1);
        in_ready  = (in_sel == SEL_OUT1) ? wr_ready1 : wr_ready0;
    end

    stream_fifo2 #(.DW(DW)) u_buf0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (in_data),
        .wr_valid (wr_valid0),
        .wr_ready (wr_ready0),
        .rd_data  (out0_data),
        .rd_valid (out0_valid),
        .rd_ready (out0_ready)
    );

    stream_fifo2 #(.DW(DW)) u_buf1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (in_data),
        .wr_valid (wr_valid1),
        .wr_ready (wr_ready1),
        .rd_data  (out1_data),
        .rd_valid (out1_valid),
        .rd_ready (out1_ready)
    );

`ifdef DEMUX_CNT_EN
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    // Delivered-beat counters; natural wrap at 2^CW.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (out0_valid && out0_ready) cnt0_d = cnt0_q + 1'b1;
        if (out1_valid && out1_ready) cnt1_d = cnt1_q + 1'b1;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule : demux1to2_stream

// File: tb/tb_demux1to2_stream.sv
// Scoreboard bench for demux1to2_stream. Reference model: one queue of
// expected beats per output; occupancy of each queue predicts valid/ready.
// Counter checks are included when DEMUX_CNT_EN is defined (CW = 4).
module tb_demux1to2_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
`ifdef DEMUX_CNT_EN
    logic [3:0] cnt0;
    logic [3:0] cnt1;
`endif

    demux1to2_stream #(.DW(8), .CW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
`ifdef DEMUX_CNT_EN
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`else
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passed = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int unsigned pops0 = 0;
    int unsigned pops1 = 0;

    logic       hold0 = 1'b0, hold1 = 1'b0;
    logic [7:0] held0, held1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // One producer cycle: drive at negedge, check model predictions at +1,
    // record the acceptance that will happen at the next rising edge.
    task automatic step(input logic v, input logic s, input logic [7:0] d,
                        input logic r0, input logic r1, output logic acc);
        logic model_rdy;
        @(negedge clk);
        in_valid = v; in_sel = s; in_data = d;
        out0_ready = r0; out1_ready = r1;
        #1;
        chk("out0_valid", {31'd0, out0_valid}, {31'd0, exp0.size() != 0});
        chk("out1_valid", {31'd0, out1_valid}, {31'd0, exp1.size() != 0});
`ifdef DEMUX_CNT_EN
        chk("cnt0", {28'd0, cnt0}, pops0 % 16);
        chk("cnt1", {28'd0, cnt1}, pops1 % 16);
`endif
        model_rdy = s ? (exp1.size() < 2) : (exp0.size() < 2);
        acc = 1'b0;
        if (v) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, model_rdy});
            if (model_rdy) begin
                acc = 1'b1;
                if (s) exp1.push_back(d);
                else   exp0.push_back(d);
            end
        end
    endtask

    // Monitor: pops and compares on every output transfer; checks stall stability.
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1) begin
            if (hold0) begin
                chk("out0_hold_valid", {31'd0, out0_valid}, 32'd1);
                chk("out0_hold_data", {24'd0, out0_data}, {24'd0, held0});
            end
            if (hold1) begin
                chk("out1_hold_valid", {31'd0, out1_valid}, 32'd1);
                chk("out1_hold_data", {24'd0, out1_data}, {24'd0, held1});
            end
            hold0 = out0_valid & ~out0_ready;
            held0 = out0_data;
            hold1 = out1_valid & ~out1_ready;
            held1 = out1_data;
            if (out0_valid && out0_ready) begin
                if (exp0.size() == 0) chk("out0_unexpected", 32'd1, 32'd0);
                else chk("out0_data", {24'd0, out0_data}, {24'd0, exp0.pop_front()});
                pops0++;
            end
            if (out1_valid && out1_ready) begin
                if (exp1.size() == 0) chk("out1_unexpected", 32'd1, 32'd0);
                else chk("out1_data", {24'd0, out1_data}, {24'd0, exp1.pop_front()});
                pops1++;
            end
        end
    end

    initial begin
        logic acc;
        int   sent;
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        #12;
        chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("rst_out0_data", {24'd0, out0_data}, 32'd0);
        chk("rst_out1_data", {24'd0, out1_data}, 32'd0);
        @(negedge clk); #3; rst_n = 1'b1;

        // Alternating route A0..A7, both consumers ready: no stalls.
        for (int unsigned i = 0; i < 8; i++) begin
            step(1'b1, i[0], 8'hA0 + 8'(i), 1'b1, 1'b1, acc);
            chk("alt_accept", {31'd0, acc}, 32'd1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Isolation: out1 blocked, 3 beats to out1 then 4 beats to out0.
        step(1'b1, 1'b1, 8'hB0, 1'b1, 1'b0, acc);
        step(1'b1, 1'b1, 8'hB1, 1'b1, 1'b0, acc);
        step(1'b1, 1'b1, 8'hB2, 1'b1, 1'b0, acc);
        chk("iso_third_stall", {31'd0, in_ready}, 32'd0);
        step(1'b1, 1'b1, 8'hB2, 1'b1, 1'b0, acc);
        for (int unsigned i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b1, 1'b0, acc);
            chk("iso_out0_flow", {31'd0, acc}, 32'd1);
        end
        chk("iso_out1_head", {24'd0, out1_data}, 32'hB0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Simultaneous write and read while holding one entry.
        step(1'b1, 1'b0, 8'h11, 1'b0, 1'b1, acc);
        step(1'b1, 1'b0, 8'h22, 1'b1, 1'b1, acc);
        chk("simul_head11", {24'd0, out0_data}, 32'h11);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        chk("simul_head22", {24'd0, out0_data}, 32'h22);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Stall retarget: out0 full, switch in_sel to empty out1.
        step(1'b1, 1'b0, 8'hD0, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, 8'hD1, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, 8'hD2, 1'b0, 1'b0, acc);
        chk("retarget_stall", {31'd0, in_ready}, 32'd0);
        in_sel = 1'b1; #1;
        chk("retarget_ready", {31'd0, in_ready}, 32'd1);
        exp1.push_back(8'hD2);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("retarget_out1", {24'd0, out1_data}, 32'hD2);
        for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Counter wrap: 17 beats on output 0.
        sent = 0;
        for (int unsigned i = 0; i < 40 && sent < 17; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b1, 1'b1, acc);
            if (acc) sent++;
        end
        for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

        // Randomized traffic with random backpressure.
        for (int unsigned i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), acc);
        end

        // Fill both buffers, then reset mid-cycle.
        for (int unsigned i = 0; i < 4; i++) step(1'b1, i[0], 8'hE0 + 8'(i), 1'b0, 1'b0, acc);
        for (int unsigned i = 0; i < 4; i++) step(1'b1, i[0], 8'hF0, 1'b0, 1'b0, acc);
        #3;
        rst_n = 1'b0;
        exp0.delete(); exp1.delete();
        pops0 = 0; pops1 = 0; hold0 = 1'b0; hold1 = 1'b0;
        #1;
        chk("mid_rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("mid_rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        in_sel = 1'b0; #1;
        chk("mid_rst_ready0", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1; #1;
        chk("mid_rst_ready1", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_CNT_EN
        chk("mid_rst_cnt0", {28'd0, cnt0}, 32'd0);
        chk("mid_rst_cnt1", {28'd0, cnt1}, 32'd0);
`endif
        in_valid = 1'b0;
        @(negedge clk); #3; rst_n = 1'b1;

        // Short post-reset traffic and drain.
        for (int unsigned i = 0; i < 20; i++)
            step(1'b1, 1'($urandom), 8'($urandom), 1'b1, 1'b1, acc);
        for (int unsigned i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        chk("drain_exp0_empty", exp0.size(), 32'd0);
        chk("drain_exp1_empty", exp1.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_demux1to2_stream
